// File: rtl/csa_serial_add_ctrl.sv
// Sequencer for a WORDS*8-bit add/subtract through one external 8-bit adder,
// one byte slice per cycle (LSB first), with a valid/ready result handshake.
module csa_serial_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [8*WORDS-1:0]   i_a,
    input  logic [8*WORDS-1:0]   i_b,
    input  logic                 i_cin,
    input  logic                 i_sub,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [8*WORDS-1:0]   o_sum,
    output logic                 o_cout,
    output logic                 o_ovf,
    output logic                 o_busy,
    output logic [7:0]           o_add_a,
    output logic [7:0]           o_add_b,
    output logic                 o_add_cin,
    input  logic [7:0]           i_add_sum,
    input  logic                 i_add_cout
);

    localparam int W  = 8 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;      // B already inverted for subtract
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;
    logic [IW-1:0]   r_idx;

    logic            w_last;
    logic [W-1:0]    w_a_shift;
    logic [W-1:0]    w_b_shift;

    assign w_last    = (r_idx == IW'(WORDS - 1));
    assign w_a_shift = r_a >> (8 * r_idx);
    assign w_b_shift = r_b >> (8 * r_idx);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours; reset is synchronous by design.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub | i_cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[8*r_idx +: 8] <= i_add_sum;
                    r_carry             <= i_add_cout;
                    r_idx               <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout  <= i_add_cout;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (i_add_sum[7] != r_a[W-1]);
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no latch forms.
    always_comb begin
        o_add_a   = 8'h00;
        o_add_b   = 8'h00;
        o_add_cin = 1'b0;
        if (r_state == S_RUN) begin
            o_add_a   = w_a_shift[7:0];
            o_add_b   = w_b_shift[7:0];
            o_add_cin = r_carry;
        end
    end

    assign o_in_ready  = (r_state == S_IDLE) && !i_rst;
    assign o_out_valid = (r_state == S_DONE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Directed bench for csa_serial_add_ctrl: a WORDS=4 and a WORDS=1 instance,
// each paired with a behavioural 8-bit adder.
module tb_csa_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // WORDS=4 instance
    logic        iv4 = 0, ir4, ov4, or4 = 0, cin4 = 0, sub4 = 0, cout4, ovf4, busy4;
    logic [31:0] a4 = 0, b4 = 0, sum4;
    logic [7:0]  aa4, ab4, as4;
    logic        ac4, aco4;

    // WORDS=1 instance
    logic        iv1 = 0, ir1, ov1, or1 = 0, cin1 = 0, sub1 = 0, cout1, ovf1, busy1;
    logic [7:0]  a1 = 0, b1 = 0, sum1;
    logic [7:0]  aa1, ab1, as1;
    logic        ac1, aco1;

    assign {aco4, as4} = {1'b0, aa4} + {1'b0, ab4} + {8'h00, ac4};
    assign {aco1, as1} = {1'b0, aa1} + {1'b0, ab1} + {8'h00, ac1};

    csa_serial_add_ctrl #(.WORDS(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(iv4), .o_in_ready(ir4),
        .i_a(a4), .i_b(b4), .i_cin(cin4), .i_sub(sub4),
        .o_out_valid(ov4), .i_out_ready(or4), .o_sum(sum4), .o_cout(cout4),
        .o_ovf(ovf4), .o_busy(busy4), .o_add_a(aa4), .o_add_b(ab4),
        .o_add_cin(ac4), .i_add_sum(as4), .i_add_cout(aco4)
    );

    csa_serial_add_ctrl #(.WORDS(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(iv1), .o_in_ready(ir1),
        .i_a(a1), .i_b(b1), .i_cin(cin1), .i_sub(sub1),
        .o_out_valid(ov1), .i_out_ready(or1), .o_sum(sum1), .o_cout(cout1),
        .o_ovf(ovf1), .o_busy(busy1), .o_add_a(aa1), .o_add_b(ab1),
        .o_add_cin(ac1), .i_add_sum(as1), .i_add_cout(aco1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op on the WORDS=4 instance, wait for the result and check it
    // together with the latency; out_ready stays low so the result is held.
    task automatic run4(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic [31:0] esum,
                        input logic ecout, input logic eovf);
        a4 = a; b4 = b; cin4 = c; sub4 = s; iv4 = 1'b1; or4 = 1'b0;
        check({tag, " in_ready"}, ir4, 1'b1);
        tick();
        iv4 = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            check({tag, " early valid"}, ov4, 1'b0);
        end
        tick();
        check({tag, " out_valid"}, ov4, 1'b1);
        check({tag, " sum"}, sum4, esum);
        check({tag, " cout"}, cout4, ecout);
        check({tag, " ovf"}, ovf4, eovf);
    endtask

    task automatic handshake4();
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
        check("handshake out_valid", ov4, 1'b0);
        check("handshake in_ready", ir4, 1'b1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst in_ready", ir4, 1'b0);
        check("rst out_valid", ov4, 1'b0);
        check("rst busy", busy4, 1'b0);
        check("rst sum", sum4, 32'h0);
        check("rst add_a", {aa4, ab4, 7'h0, ac4}, 24'h0);
        rst = 1'b0;
        #1;
        check("idle in_ready", ir4, 1'b1);

        // 1: carry ripples through every slice; first-slice adder drive
        a4 = 32'hFFFFFFFF; b4 = 32'h1; cin4 = 0; sub4 = 0; iv4 = 1;
        tick();
        iv4 = 0;
        check("t1 add_a s0", aa4, 8'hFF);
        check("t1 add_b s0", ab4, 8'h01);
        check("t1 add_cin s0", ac4, 1'b0);
        check("t1 busy", busy4, 1'b1);
        check("t1 in_ready run", ir4, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("t1 early valid", ov4, 1'b0);
        end
        tick();
        check("t1 out_valid", ov4, 1'b1);
        check("t1 sum", sum4, 32'h00000000);
        check("t1 cout", cout4, 1'b1);
        check("t1 ovf", ovf4, 1'b0);
        check("t1 add idle", {aa4, ab4, 7'h0, ac4}, 24'h0);
        handshake4();

        // 2: subtract forces carry-in 1 and inverts B
        a4 = 32'h5; b4 = 32'h7; cin4 = 0; sub4 = 1; iv4 = 1;
        tick();
        iv4 = 0;
        check("t2 add_cin s0", ac4, 1'b1);
        check("t2 add_b s0", ab4, 8'hF8);
        tick(); tick(); tick();
        check("t2 early valid", ov4, 1'b0);
        tick();
        check("t2 out_valid", ov4, 1'b1);
        check("t2 sum", sum4, 32'hFFFFFFFE);
        check("t2 cout", cout4, 1'b0);
        check("t2 ovf", ovf4, 1'b0);
        handshake4();

        // 3: signed overflow, add and subtract
        run4("t3a", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        handshake4();
        run4("t3b", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        handshake4();
        run4("cin", 32'h0000FFFF, 32'h1, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0);
        handshake4();

        // 4: back-pressure in DONE with a new op already offered
        run4("t4", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
        a4 = 32'h1; b4 = 32'h2; cin4 = 0; sub4 = 0; iv4 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4 hold valid", ov4, 1'b1);
            check("t4 hold sum", sum4, 32'h23456789);
            check("t4 hold in_ready", ir4, 1'b0);
        end
        or4 = 1;
        tick();
        or4 = 0;
        check("t4 released valid", ov4, 1'b0);
        check("t4 released in_ready", ir4, 1'b1);
        check("t4 sum kept", sum4, 32'h23456789);
        tick();
        iv4 = 0;
        check("t4 second accepted", busy4, 1'b1);
        tick(); tick(); tick();
        check("t4 second early", ov4, 1'b0);
        tick();
        check("t4 second valid", ov4, 1'b1);
        check("t4 second sum", sum4, 32'h00000003);
        handshake4();

        // 5: reset while slice 2 is in the adder aborts the op
        a4 = 32'hAAAAAAAA; b4 = 32'h55555555; cin4 = 0; sub4 = 0; iv4 = 1;
        tick();
        iv4 = 0;
        tick(); tick();
        check("t5 slice2 add_a", aa4, 8'hAA);
        rst = 1;
        #1;
        check("t5 rst in_ready", ir4, 1'b0);
        tick();
        rst = 0;
        #1;
        check("t5 idle in_ready", ir4, 1'b1);
        check("t5 busy", busy4, 1'b0);
        check("t5 sum cleared", sum4, 32'h0);
        for (int k = 0; k < 5; k++) begin
            check("t5 no valid", ov4, 1'b0);
            tick();
        end
        run4("t5 next", 32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0, 32'hDFAEBFF0, 1'b0, 1'b0);
        handshake4();

        // 6: WORDS=1 single-slice op, then back-to-back throughput
        a1 = 8'h80; b1 = 8'h80; cin1 = 0; sub1 = 0; iv1 = 1; or1 = 0;
        check("t6 in_ready", ir1, 1'b1);
        tick();
        iv1 = 0;
        check("t6 add_a", aa1, 8'h80);
        check("t6 run valid", ov1, 1'b0);
        tick();
        check("t6 out_valid", ov1, 1'b1);
        check("t6 sum", sum1, 8'h00);
        check("t6 cout", cout1, 1'b1);
        check("t6 ovf", ovf1, 1'b1);
        or1 = 1;
        tick();
        a1 = 8'h03; b1 = 8'h04; iv1 = 1;
        for (int c = 0; c < 9; c++) begin
            check("t6 b2b in_ready", ir1, (c % 3) == 0);
            check("t6 b2b out_valid", ov1, (c % 3) == 2);
            if ((c % 3) == 2) check("t6 b2b sum", sum1, 8'h07);
            tick();
        end
        iv1 = 0;
        or1 = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
